forward_select_ctrl: RTL and testbench

FORWARD_SELECT_CTRL -- requirements
Module: forward_select_ctrl

---
 rtl/forward_select_ctrl_if.sv | 28 ++
 rtl/forward_select_ctrl.sv | 97 +++++++++
 tb/tb_forward_select_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/forward_select_ctrl_if.sv
// Decode-to-EX forwarding control bus: decode-stage fields and pipeline control in,
// registered operand-mux selects, EX-slot liveness and the load-use stall request out.
interface forward_select_ctrl_if #(
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic            id_regwrite;
    logic            id_memread;
    logic            stall_in;
    logic            flush;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic            hazard_stall;
    logic            ex_valid;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, stall_in, flush,
        input  fwd_a_sel, fwd_b_sel, hazard_stall, ex_valid
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, stall_in, flush,
        output fwd_a_sel, fwd_b_sel, hazard_stall, ex_valid
    );
endinterface

// File: rtl/forward_select_ctrl.sv
// EX/MEM/WB history tracker producing registered forwarding selects and a load-use stall.
// Define FWD_WB_BYPASS_EN to enable the WB write-through select (code 11).
module forward_select_ctrl #(
    parameter int RA_W = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    forward_select_ctrl_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } slot_t;

    localparam slot_t BUBBLE = '0;

`ifdef FWD_WB_BYPASS_EN
    localparam logic [1:0] WB_SEL = 2'b11;
`else
    localparam logic [1:0] WB_SEL = 2'b00;
`endif

    slot_t      ex_slot;
    slot_t      mem_slot;
    slot_t      wb_slot;
    slot_t      id_slot;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [1:0] a_sel_next;
    logic [1:0] b_sel_next;
    logic       load_use;
    logic       bubble_edge;
    logic       unused_bits;

    function automatic logic slot_hit(input slot_t s, input logic [RA_W-1:0] src);
        return s.valid && s.regwrite && (s.rd == src) && (src != '0);
    endfunction

    assign id_slot = '{valid:    bus.id_valid,
                       rd:       bus.id_rd,
                       regwrite: bus.id_regwrite,
                       memread:  bus.id_memread};

    // A load in EX cannot forward yet; the consumer must wait one cycle and pick it up from MEM.
    assign load_use = bus.id_valid && !bus.flush
                   && ex_slot.valid && ex_slot.memread && ex_slot.regwrite
                   && (ex_slot.rd != '0)
                   && ((ex_slot.rd == bus.id_rs1) || (ex_slot.rd == bus.id_rs2));

    assign bubble_edge = bus.flush || (!bus.stall_in && load_use);

    // Oldest slot is tested first so a younger match overrides it.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a select unassigned (no latch).
        a_sel_next = 2'b00;
        b_sel_next = 2'b00;
        if (slot_hit(wb_slot, bus.id_rs1))  a_sel_next = WB_SEL;
        if (slot_hit(wb_slot, bus.id_rs2))  b_sel_next = WB_SEL;
        if (slot_hit(mem_slot, bus.id_rs1)) a_sel_next = 2'b10;
        if (slot_hit(mem_slot, bus.id_rs2)) b_sel_next = 2'b10;
        if (slot_hit(ex_slot, bus.id_rs1))  a_sel_next = 2'b01;
        if (slot_hit(ex_slot, bus.id_rs2))  b_sel_next = 2'b01;
    end

    // NOTE: sequential state uses non-blocking assignments so all slots shift on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot  <= BUBBLE;
            mem_slot <= BUBBLE;
            wb_slot  <= BUBBLE;
            a_sel    <= 2'b00;
            b_sel    <= 2'b00;
        end else if (bubble_edge) begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            ex_slot  <= BUBBLE;
            a_sel    <= 2'b00;
            b_sel    <= 2'b00;
        end else if (!bus.stall_in) begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            ex_slot  <= id_slot;
            a_sel    <= a_sel_next;
            b_sel    <= b_sel_next;
        end
    end

    assign bus.fwd_a_sel    = a_sel;
    assign bus.fwd_b_sel    = b_sel;
    assign bus.ex_valid     = ex_slot.valid;
    assign bus.hazard_stall = load_use;

    // Load flags only matter while the instruction sits in EX.
    assign unused_bits = &{1'b0, mem_slot.memread, wb_slot.memread};
endmodule

// File: tb/tb_forward_select_ctrl.sv
// Randomized and directed bench for forward_select_ctrl against an age-indexed history model.
module tb_forward_select_ctrl;
    localparam int RA_W = 5;
`ifdef FWD_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

    typedef struct {
        bit            valid;
        bit [RA_W-1:0] rd;
        bit            rw;
        bit            mr;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    forward_select_ctrl_if #(.RA_W(RA_W)) bus ();
    forward_select_ctrl #(.RA_W(RA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Model: hist[age] with age 0 = EX, 1 = MEM, 2 = WB.
    rec_t     hist [3];
    bit [1:0] exp_a;
    bit [1:0] exp_b;

    function automatic bit [1:0] m_sel(input bit [RA_W-1:0] src);
        if (src == 0) return 2'b00;
        for (int age = 0; age < 3; age++) begin
            if (hist[age].valid && hist[age].rw && hist[age].rd == src) begin
                if (age == 2 && !WB_BYPASS) return 2'b00;
                return 2'(age + 1);
            end
        end
        return 2'b00;
    endfunction

    function automatic bit m_hazard();
        if (bus.flush || !bus.id_valid) return 1'b0;
        return hist[0].valid && hist[0].mr && hist[0].rw && hist[0].rd != 0
            && (hist[0].rd == bus.id_rs1 || hist[0].rd == bus.id_rs2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '{valid: 0, rd: 0, rw: 0, mr: 0};
        exp_a = 2'b00;
        exp_b = 2'b00;
    endtask

    task automatic apply(input bit v, input bit [RA_W-1:0] rs1, input bit [RA_W-1:0] rs2,
                         input bit [RA_W-1:0] rd, input bit rw, input bit mr,
                         input bit stall, input bit fl);
        bus.id_valid    = v;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.stall_in    = stall;
        bus.flush       = fl;
        #1;
    endtask

    task automatic clock_edge();
        bit       haz;
        bit [1:0] na;
        bit [1:0] nb;
        rec_t     dec;
        haz = m_hazard();
        na  = m_sel(bus.id_rs1);
        nb  = m_sel(bus.id_rs2);
        dec = '{valid: bus.id_valid, rd: bus.id_rd, rw: bus.id_regwrite, mr: bus.id_memread};
        if (bus.flush || (!bus.stall_in && haz)) begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = '{valid: 0, rd: 0, rw: 0, mr: 0};
            exp_a = 2'b00;
            exp_b = 2'b00;
        end else if (!bus.stall_in) begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = dec;
            exp_a = na;
            exp_b = nb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        apply(1, 3, 3, 3, 1, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid, bus.hazard_stall} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid, bus.hazard_stall});
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 0, 0, 4, 1, 0, 0, 0);
        clock_edge();
        checks++;
        if (bus.ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_resume_ex_valid: got %b expected 1", bus.ex_valid);
        end
    endtask

    task automatic test_ex_forward();
        apply(1, 1, 2, 5, 1, 0, 0, 0);
        clock_edge();
        apply(1, 5, 3, 6, 1, 0, 0, 0);
        checks++;
        if (bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL ex_fwd_no_stall: got %b expected 0", bus.hazard_stall);
        end
        clock_edge();
        checks++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid} !== 5'b01_00_1) begin
            errors++;
            $display("FAIL ex_fwd_sel: got %b expected 01001",
                     {bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid});
        end
    endtask

    task automatic test_load_use();
        apply(1, 0, 0, 7, 1, 1, 0, 0);
        clock_edge();
        apply(1, 7, 7, 8, 1, 0, 0, 0);
        checks++;
        if (bus.hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: got %b expected 1", bus.hazard_stall);
        end
        clock_edge();
        checks++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid} !== 5'b00_00_0) begin
            errors++;
            $display("FAIL load_use_bubble: got %b expected 00000",
                     {bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid});
        end
        checks++;
        if (bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_stall_clear: got %b expected 0", bus.hazard_stall);
        end
        clock_edge();
        checks++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid} !== 5'b10_10_1) begin
            errors++;
            $display("FAIL load_use_mem_fwd: got %b expected 10101",
                     {bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid});
        end
    endtask

    task automatic test_x0();
        apply(1, 0, 0, 0, 1, 1, 0, 0);
        clock_edge();
        apply(1, 0, 0, 9, 1, 0, 0, 0);
        checks++;
        if (bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_no_stall: got %b expected 0", bus.hazard_stall);
        end
        clock_edge();
        checks++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid} !== 5'b00_00_1) begin
            errors++;
            $display("FAIL x0_sel: got %b expected 00001",
                     {bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid});
        end
    endtask

    task automatic test_wb_distance();
        bit [1:0] wb_exp;
        wb_exp = WB_BYPASS ? 2'b11 : 2'b00;
        apply(1, 1, 1, 12, 1, 0, 0, 0);
        clock_edge();
        apply(1, 1, 2, 13, 1, 0, 0, 0);
        clock_edge();
        apply(1, 2, 4, 14, 1, 0, 0, 0);
        clock_edge();
        apply(1, 12, 12, 19, 1, 0, 0, 0);
        clock_edge();
        checks++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel} !== {wb_exp, wb_exp}) begin
            errors++;
            $display("FAIL wb_distance_sel: got %b expected %b",
                     {bus.fwd_a_sel, bus.fwd_b_sel}, {wb_exp, wb_exp});
        end
        apply(1, 1, 1, 16, 1, 0, 0, 0);
        clock_edge();
        apply(1, 2, 4, 17, 1, 0, 0, 0);
        clock_edge();
        apply(1, 16, 0, 20, 1, 0, 0, 0);
        clock_edge();
        checks++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid} !== 5'b10_00_1) begin
            errors++;
            $display("FAIL mem_distance_sel: got %b expected 10001",
                     {bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid});
        end
    endtask

    task automatic test_stall_flush();
        apply(1, 0, 0, 11, 1, 1, 0, 0);
        clock_edge();
        apply(1, 11, 3, 18, 1, 0, 1, 0);
        checks++;
        if (bus.hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_hazard_visible: got %b expected 1", bus.hazard_stall);
        end
        clock_edge();
        checks++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid} !== 5'b00_00_1) begin
            errors++;
            $display("FAIL stall_hold: got %b expected 00001",
                     {bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid});
        end
        apply(1, 11, 3, 18, 1, 0, 1, 1);
        checks++;
        if (bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_masks_stall: got %b expected 0", bus.hazard_stall);
        end
        clock_edge();
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble: got %b expected 0", bus.ex_valid);
        end
        apply(1, 11, 3, 18, 1, 0, 1, 0);
        clock_edge();
        checks++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid} !== 5'b00_00_0) begin
            errors++;
            $display("FAIL stall_after_flush_hold: got %b expected 00000",
                     {bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid});
        end
        apply(1, 11, 3, 18, 1, 0, 0, 0);
        clock_edge();
        checks++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid} !== 5'b10_00_1) begin
            errors++;
            $display("FAIL post_flush_mem_fwd: got %b expected 10001",
                     {bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid});
        end
        // Asynchronous reset while frozen must clear everything before any clock edge.
        apply(1, 11, 11, 20, 1, 0, 1, 0);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid, bus.hazard_stall} !== 6'b0) begin
            errors++;
            $display("FAIL midstall_reset_outputs: got %b expected 000000",
                     {bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid, bus.hazard_stall});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply(1, 18, 18, 21, 1, 0, 0, 0);
        clock_edge();
        checks++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid} !== 5'b00_00_1) begin
            errors++;
            $display("FAIL midstall_reset_discard: got %b expected 00001",
                     {bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom % 4) != 0,
                  RA_W'($urandom % 4), RA_W'($urandom % 4), RA_W'($urandom % 4),
                  ($urandom % 4) != 0, ($urandom % 3) == 0,
                  ($urandom % 6) == 0, ($urandom % 10) == 0);
            checks++;
            if (bus.hazard_stall !== m_hazard()) begin
                errors++;
                $display("FAIL rand_hazard[%0d]: got %b expected %b", i, bus.hazard_stall, m_hazard());
            end
            clock_edge();
            checks++;
            if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid} !== {exp_a, exp_b, hist[0].valid}) begin
                errors++;
                $display("FAIL rand_outputs[%0d]: got %b expected %b", i,
                         {bus.fwd_a_sel, bus.fwd_b_sel, bus.ex_valid}, {exp_a, exp_b, hist[0].valid});
            end
        end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_load_use();
        test_x0();
        test_wb_distance();
        test_stall_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
